// File: rtl/gppcu_scoreboard_if.sv
// gppcu_scoreboard_if
//   Issue/write-back bundle between the GPPCU issue stage and its register
//   scoreboard. Signal names keep the scoreboard's i/o prefixes so that the
//   direction is read from the scoreboard's point of view.
//
//   Handshake: an instruction is presented with iISSUE_VALID; the scoreboard
//   answers combinationally with oISSUE_READY (which never depends on
//   iISSUE_VALID). The instruction issues in a cycle where both are 1 at the
//   rising clock edge; the presenter must hold its operands while valid and
//   not ready.
//
//   Signals:
//     iISSUE_VALID, oISSUE_READY        issue handshake
//     iREGD/iVALID_REGD                 destination register
//     iREGA/iVALID_REGA, iREGB/...      source registers
//     iWB_REG[NUMWB*RBW], iWB_VALID     write-back (retire) ports
//     iFLUSH                            clear all tracking
//     oBUSY[NUMREG], oIDLE, oERR        registered status
//   Modports: master = issue stage, slave = scoreboard.
interface gppcu_scoreboard_if #(
    parameter int NUMREG = 32,
    parameter int NUMWB  = 2
);
    localparam int RBW = (NUMREG > 1) ? $clog2(NUMREG) : 1;

    logic                   iISSUE_VALID;
    logic                   oISSUE_READY;
    logic [RBW-1:0]         iREGD;
    logic                   iVALID_REGD;
    logic [RBW-1:0]         iREGA;
    logic                   iVALID_REGA;
    logic [RBW-1:0]         iREGB;
    logic                   iVALID_REGB;
    logic [NUMWB*RBW-1:0]   iWB_REG;
    logic [NUMWB-1:0]       iWB_VALID;
    logic                   iFLUSH;
    logic [NUMREG-1:0]      oBUSY;
    logic                   oIDLE;
    logic                   oERR;

    modport master (
        output iISSUE_VALID, iREGD, iVALID_REGD, iREGA, iVALID_REGA,
               iREGB, iVALID_REGB, iWB_REG, iWB_VALID, iFLUSH,
        input  oISSUE_READY, oBUSY, oIDLE, oERR
    );

    modport slave (
        input  iISSUE_VALID, iREGD, iVALID_REGD, iREGA, iVALID_REGA,
               iREGB, iVALID_REGB, iWB_REG, iWB_VALID, iFLUSH,
        output oISSUE_READY, oBUSY, oIDLE, oERR
    );
endinterface

// File: rtl/gppcu_scoreboard.sv
// gppcu_scoreboard
//   Register scoreboard for the GPPCU issue stage. Each architectural register
//   has a saturating counter of outstanding writes, so several writes to the
//   same register may be in flight. Read-after-write hazards and counter
//   saturation hold off issue; any number of write-back ports retire writes.
//
//   Ports:
//     iACLK   clock, rising edge
//     inRST   asynchronous active-low reset
//     bus     gppcu_scoreboard_if.slave (issue handshake, write-back, status)
//
//   Parameters:
//     NUMREG   architectural registers
//     NUMWB    write-back ports
//     CNTW     counter width (max outstanding writes 2^CNTW-1)
//     BYPASS   1: a register whose count fully retires this cycle is not a hazard
//     ZERO_REG 1: register 0 is never tracked
module gppcu_scoreboard #(
    parameter int NUMREG   = 32,
    parameter int NUMWB    = 2,
    parameter int CNTW     = 2,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 1
) (
    input  logic iACLK,
    input  logic inRST,
    gppcu_scoreboard_if.slave bus
);
    localparam int RBW  = (NUMREG > 1) ? $clog2(NUMREG) : 1;
    localparam int NIDX = 1 << RBW;
    localparam int RW   = $clog2(NUMWB + 1);
    localparam int SW   = CNTW + RW + 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] cnt_q [NUMREG];
    logic [CNTW-1:0] cnt_d [NUMREG];
    logic            err_q, err_d;

    logic [RW-1:0]   ret_n [NUMREG];
    // Sized to the full index range so an out-of-range register number reads 0.
    logic [NIDX-1:0] busy_e;
    logic [NIDX-1:0] sat;
    logic            haz_a, haz_b, sat_d, ready, fire;
    logic [NUMREG-1:0] busy;

    logic            inc_v;
    logic [SW-1:0]   up_v, dn_v;

    // Number of write-back ports retiring each register this cycle.
    always_comb begin
        for (int r = 0; r < NUMREG; r++) begin
            ret_n[r] = '0;
            for (int k = 0; k < NUMWB; k++) begin
                if (bus.iWB_VALID[k] && (bus.iWB_REG[k*RBW +: RBW] == RBW'(r))) begin
                    ret_n[r] = ret_n[r] + RW'(1);
                end
            end
        end
    end

    // Per-register hazard terms. Leaving entry 0 at 0 when ZERO_REG is set
    // masks every hazard/saturation term that names register 0.
    always_comb begin
        busy_e = '0;
        sat    = '0;
        for (int r = 0; r < NUMREG; r++) begin
            if (!((ZERO_REG != 0) && (r == 0))) begin
                if (BYPASS != 0) begin
                    busy_e[r] = SW'(cnt_q[r]) > SW'(ret_n[r]);
                end else begin
                    busy_e[r] = cnt_q[r] != '0;
                end
                sat[r] = cnt_q[r] == CNT_MAX;
            end
        end
    end

    assign haz_a = bus.iVALID_REGA & busy_e[bus.iREGA];
    assign haz_b = bus.iVALID_REGB & busy_e[bus.iREGB];
    assign sat_d = bus.iVALID_REGD & sat[bus.iREGD];
    assign ready = ~bus.iFLUSH & ~haz_a & ~haz_b & ~sat_d;
    assign fire  = bus.iISSUE_VALID & ready;

    // Counter update: net of this cycle's issue and retires, clamped at 0.
    // The upper bound needs no clamp because sat_d blocks an increment at max.
    always_comb begin
        err_d = err_q;
        inc_v = 1'b0;
        up_v  = '0;
        dn_v  = '0;
        for (int r = 0; r < NUMREG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_v    = fire & bus.iVALID_REGD & (bus.iREGD == RBW'(r));
            up_v     = SW'(cnt_q[r]) + SW'(inc_v);
            dn_v     = SW'(ret_n[r]);
            if ((ZERO_REG != 0) && (r == 0)) begin
                cnt_d[r] = '0;
            end else if (bus.iFLUSH) begin
                cnt_d[r] = '0;
            end else if (dn_v > up_v) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNTW'(up_v - dn_v);
            end
        end
    end

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            for (int r = 0; r < NUMREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUMREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NUMREG; r++) begin
            busy[r] = cnt_q[r] != '0;
        end
    end

    assign bus.oISSUE_READY = ready;
    assign bus.oBUSY        = busy;
    assign bus.oIDLE        = ~|busy;
    assign bus.oERR         = err_q;
endmodule

// File: tb/tb_gppcu_scoreboard.sv
// Directed bench for gppcu_scoreboard. Two instances (BYPASS=0 and BYPASS=1)
// share one stimulus stream; inputs change 1 ns after a rising edge, the
// combinational ready is sampled 1 ns later and registered status 1 ns after
// the following edge.
module tb_gppcu_scoreboard;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gppcu_scoreboard_if #(.NUMREG(32), .NUMWB(2)) bus0 ();
    gppcu_scoreboard_if #(.NUMREG(32), .NUMWB(2)) bus1 ();

    gppcu_scoreboard #(.NUMREG(32), .NUMWB(2), .CNTW(2), .BYPASS(0), .ZERO_REG(1)) dut0 (
        .iACLK(clk), .inRST(rst_n), .bus(bus0)
    );
    gppcu_scoreboard #(.NUMREG(32), .NUMWB(2), .CNTW(2), .BYPASS(1), .ZERO_REG(1)) dut1 (
        .iACLK(clk), .inRST(rst_n), .bus(bus1)
    );

    assign bus1.iISSUE_VALID = bus0.iISSUE_VALID;
    assign bus1.iREGD        = bus0.iREGD;
    assign bus1.iVALID_REGD  = bus0.iVALID_REGD;
    assign bus1.iREGA        = bus0.iREGA;
    assign bus1.iVALID_REGA  = bus0.iVALID_REGA;
    assign bus1.iREGB        = bus0.iREGB;
    assign bus1.iVALID_REGB  = bus0.iVALID_REGB;
    assign bus1.iWB_REG      = bus0.iWB_REG;
    assign bus1.iWB_VALID    = bus0.iWB_VALID;
    assign bus1.iFLUSH       = bus0.iFLUSH;

    task automatic clear_in();
        bus0.iISSUE_VALID = 1'b0;
        bus0.iREGD = '0; bus0.iVALID_REGD = 1'b0;
        bus0.iREGA = '0; bus0.iVALID_REGA = 1'b0;
        bus0.iREGB = '0; bus0.iVALID_REGB = 1'b0;
        bus0.iWB_REG = '0; bus0.iWB_VALID = '0;
        bus0.iFLUSH = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_d(input logic [4:0] d);
        bus0.iISSUE_VALID = 1'b1;
        bus0.iREGD = d; bus0.iVALID_REGD = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        #2;
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", bus0.oIDLE); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus0.oERR); end
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus0.oISSUE_READY); end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        issue_d(5'd5);
        bus0.iREGA = 5'd1; bus0.iVALID_REGA = 1'b1;
        bus0.iREGB = 5'd2; bus0.iVALID_REGB = 1'b1;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL basic_ready0 got %b exp 1", bus0.oISSUE_READY); end
        checks++; if (bus1.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL basic_ready1 got %b exp 1", bus1.oISSUE_READY); end
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h20) begin errors++; $display("FAIL basic_busy got %h exp %h", bus0.oBUSY, 32'h20); end
        checks++; if (bus0.oIDLE !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", bus0.oIDLE); end
        bus0.iREGA = 5'd5; bus0.iVALID_REGA = 1'b1;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL raw_ready0 got %b exp 0", bus0.oISSUE_READY); end
        checks++; if (bus1.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL raw_ready1 got %b exp 0", bus1.oISSUE_READY); end
        bus0.iWB_REG = {5'd0, 5'd5}; bus0.iWB_VALID = 2'b01;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL wb_nobypass_ready got %b exp 0", bus0.oISSUE_READY); end
        checks++; if (bus1.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL wb_bypass_ready got %b exp 1", bus1.oISSUE_READY); end
        tick();
        bus0.iWB_REG = '0; bus0.iWB_VALID = '0;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL after_wb_ready0 got %b exp 1", bus0.oISSUE_READY); end
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL after_wb_idle got %b exp 1", bus0.oIDLE); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL after_wb_err got %b exp 0", bus0.oERR); end
        clear_in();
    endtask

    task automatic test_saturate();
        issue_d(5'd7);
        tick(); tick(); tick();
        #1;
        checks++; if (bus0.oBUSY !== 32'h80) begin errors++; $display("FAIL sat_busy got %h exp %h", bus0.oBUSY, 32'h80); end
        checks++; if (bus0.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_ready0 got %b exp 0", bus0.oISSUE_READY); end
        checks++; if (bus1.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_ready1 got %b exp 0", bus1.oISSUE_READY); end
        bus0.iWB_REG = {5'd0, 5'd7}; bus0.iWB_VALID = 2'b01;
        tick();
        bus0.iWB_REG = '0; bus0.iWB_VALID = '0;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL sat_release_ready got %b exp 1", bus0.oISSUE_READY); end
        tick();
        bus0.iISSUE_VALID = 1'b0;
        #1;
        // Fourth issue fired: back at the maximum count.
        checks++; if (bus0.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL sat_refill_ready got %b exp 0", bus0.oISSUE_READY); end
        clear_in();
        bus0.iWB_REG = {5'd7, 5'd7}; bus0.iWB_VALID = 2'b11;
        tick();
        bus0.iWB_VALID = 2'b01;
        tick();
        clear_in();
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL sat_drain_idle got %b exp 1", bus0.oIDLE); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL sat_drain_err got %b exp 0", bus0.oERR); end
    endtask

    task automatic test_same_cycle();
        issue_d(5'd9);
        tick();
        bus0.iWB_REG = {5'd9, 5'd0}; bus0.iWB_VALID = 2'b10;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL same_ready got %b exp 1", bus0.oISSUE_READY); end
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h200) begin errors++; $display("FAIL same_busy got %h exp %h", bus0.oBUSY, 32'h200); end
        checks++; if (bus1.oBUSY !== 32'h200) begin errors++; $display("FAIL same_busy1 got %h exp %h", bus1.oBUSY, 32'h200); end
        bus0.iWB_REG = {5'd0, 5'd9}; bus0.iWB_VALID = 2'b01;
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL same_drain_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL same_drain_err got %b exp 0", bus0.oERR); end
    endtask

    task automatic test_zero_reg();
        issue_d(5'd0);
        bus0.iREGA = 5'd0; bus0.iVALID_REGA = 1'b1;
        tick();
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", bus0.oISSUE_READY); end
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL zero_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        bus0.iWB_REG = {5'd0, 5'd0}; bus0.iWB_VALID = 2'b01;
        tick();
        clear_in();
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL zero_wb_err got %b exp 0", bus0.oERR); end
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL zero_idle got %b exp 1", bus0.oIDLE); end
    endtask

    task automatic test_flush();
        issue_d(5'd4);
        tick(); tick();
        issue_d(5'd6);
        bus0.iFLUSH = 1'b1;
        #1;
        checks++; if (bus0.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL flush_ready0 got %b exp 0", bus0.oISSUE_READY); end
        checks++; if (bus1.oISSUE_READY !== 1'b0) begin errors++; $display("FAIL flush_ready1 got %b exp 0", bus1.oISSUE_READY); end
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL flush_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL flush_idle got %b exp 1", bus0.oIDLE); end
    endtask

    task automatic test_dual_retire();
        issue_d(5'd3);
        tick(); tick();
        clear_in();
        bus0.iWB_REG = {5'd3, 5'd3}; bus0.iWB_VALID = 2'b11;
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL dual_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL dual_err got %b exp 0", bus0.oERR); end
        issue_d(5'd3);
        tick();
        clear_in();
        bus0.iWB_REG = {5'd3, 5'd3}; bus0.iWB_VALID = 2'b11;
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL under_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oERR !== 1'b1) begin errors++; $display("FAIL under_err0 got %b exp 1", bus0.oERR); end
        checks++; if (bus1.oERR !== 1'b1) begin errors++; $display("FAIL under_err1 got %b exp 1", bus1.oERR); end
        tick(); tick();
        checks++; if (bus0.oERR !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", bus0.oERR); end
    endtask

    task automatic test_reset_mid();
        issue_d(5'd10);
        tick();
        clear_in();
        checks++; if (bus0.oBUSY !== 32'h400) begin errors++; $display("FAIL mid_pre_busy got %h exp %h", bus0.oBUSY, 32'h400); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus0.oBUSY !== 32'h0) begin errors++; $display("FAIL mid_busy got %h exp %h", bus0.oBUSY, 32'h0); end
        checks++; if (bus0.oIDLE !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", bus0.oIDLE); end
        checks++; if (bus0.oERR !== 1'b0) begin errors++; $display("FAIL mid_err_clr got %b exp 0", bus0.oERR); end
        rst_n = 1'b1;
        bus0.iWB_REG = {5'd0, 5'd10}; bus0.iWB_VALID = 2'b01;
        tick();
        clear_in();
        checks++; if (bus0.oERR !== 1'b1) begin errors++; $display("FAIL mid_wb_err0 got %b exp 1", bus0.oERR); end
        checks++; if (bus1.oERR !== 1'b1) begin errors++; $display("FAIL mid_wb_err1 got %b exp 1", bus1.oERR); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_same_cycle();
        test_zero_reg();
        test_flush();
        test_dual_retire();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
